ex_trap_ctrl: RTL and testbench

External interrupt controller that sits directly upstream of the core's external trap port. It collects up to 32 raw interrupt lines and latches them as pending. It selects the lowest-numbered enabled pending source and presents it to the core over the `core_ex_trap_valid/id/ready` handshake. It also exposes enable, pending and edge-select registers as an ICB slave on bus slot s3.

---
 rtl/ex_trap_ctrl_pkg.sv | 31 +++
 rtl/ex_trap_ctrl_if.sv | 39 +++
 rtl/ex_trap_ctrl_prio_enc32.sv | 24 ++
 rtl/ex_trap_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ex_trap_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_trap_ctrl_pkg
// Description : Shared constants, FSM encoding and helpers for the external
//               trap controller (register offsets, ID width, byte masks).
// Revision    : 1.0 - initial release
// ============================================================================
package ex_trap_ctrl_pkg;

  // Width of the source ID presented to the core
  localparam int EXTRAP_ID_W = 5;

  // Register offsets within the 16-byte window (decoded from addr[3:2])
  localparam logic [3:0] EXTRAP_IE   = 4'h0;
  localparam logic [3:0] EXTRAP_IP   = 4'h4;
  localparam logic [3:0] EXTRAP_EDGE = 4'h8;
  localparam logic [3:0] EXTRAP_CUR  = 4'hC;

  // Delivery FSM: either waiting for work or holding an offer to the core
  typedef enum logic [0:0] {
    EXTRAP_ST_IDLE  = 1'b0,
    EXTRAP_ST_OFFER = 1'b1
  } extrap_state_t;

  // Expand a 4-bit byte-lane mask into a 32-bit bit mask
  function automatic logic [31:0] extrap_bmask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_trap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_trap_ctrl_if
// Description : ICB slave port plus core trap handshake for ex_trap_ctrl.
//               master = bus/core side, slave = controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_trap_ctrl_if;
  import ex_trap_ctrl_pkg::*;

  logic                   icb_cmd_valid;
  logic                   icb_cmd_ready;
  logic [31:0]            icb_cmd_addr;
  logic                   icb_cmd_read;
  logic [31:0]            icb_cmd_wdata;
  logic [3:0]             icb_cmd_wmask;
  logic                   icb_rsp_valid;
  logic                   icb_rsp_ready;
  logic                   icb_rsp_err;
  logic [31:0]            icb_rsp_rdata;
  logic                   trap_valid_o;
  logic [EXTRAP_ID_W-1:0] trap_id_o;
  logic                   trap_ready_i;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
           icb_cmd_wmask, icb_rsp_ready, trap_ready_i,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata,
           trap_valid_o, trap_id_o
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
           icb_cmd_wmask, icb_rsp_ready, trap_ready_i,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata,
           trap_valid_o, trap_id_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_trap_ctrl_prio_enc32.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc32
// Description : Combinational lowest-set-bit encoder over 32 requests,
//               returning {any, id[4:0]}.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc32 (
  input  logic [31:0] i_req,
  output logic        o_any,
  output logic [4:0]  o_id
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    o_any = |i_req;
    o_id  = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (i_req[i]) o_id = i[4:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ex_trap_ctrl
// Description : External interrupt controller. Latches up to 32 irq lines
//               as pending, offers the lowest enabled pending source to the
//               core, and exposes IE/IP/EDGE/CUR registers on an ICB slave.
//               Build option EXTRAP_SYNC_EN adds a 2-flop input synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_trap_ctrl
  import ex_trap_ctrl_pkg::*;
#(
  parameter int IRQ_NUM = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IRQ_NUM-1:0] irq_i,
  ex_trap_ctrl_if.slave      bus
);

  // Bits above IRQ_NUM never hold state, so they read 0 and ignore writes
  localparam logic [31:0] C_IRQ_MASK =
    (IRQ_NUM >= 32) ? 32'hFFFF_FFFF : ((32'd1 << IRQ_NUM) - 32'd1);

  logic [31:0]             w_irq32;
  logic [31:0]             w_q;
  logic [31:0]             r_q_d;
  logic [31:0]             r_ie, r_ip, r_edge;
  logic [31:0]             w_set, w_bus_clr, w_ack_clr, w_bmask, w_rd_data;
  logic                    w_cmd_hs, w_addr_err, w_wr;
  logic [3:0]              w_sel;
  logic                    r_rsp_valid, r_rsp_err;
  logic [31:0]             r_rsp_rdata;
  extrap_state_t           r_state, w_state_nxt;
  logic [EXTRAP_ID_W-1:0]  r_id, w_enc_id;
  logic                    w_any, w_id_load, w_trap_valid, w_ack;
  logic                    w_unused_addr;

  generate
    if (IRQ_NUM < 32) begin : g_irq_pad
      assign w_irq32 = {{(32-IRQ_NUM){1'b0}}, irq_i};
    end else begin : g_irq_full
      assign w_irq32 = irq_i;
    end
  endgenerate

`ifdef EXTRAP_SYNC_EN
  logic [31:0] r_sync1, r_sync2;
  // Two-stage synchronizer for asynchronous board pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_irq32;
      r_sync2 <= r_sync1;
    end
  end
  assign w_q = r_sync2;
`else
  assign w_q = w_irq32;
`endif

  // One-cycle delay of the qualified lines for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q_d <= '0;
    else        r_q_d <= w_q;
  end

  assign w_set = ((r_edge & w_q & ~r_q_d) | (~r_edge & w_q)) & C_IRQ_MASK;

  // ICB decode; only one response is ever outstanding
  assign bus.icb_cmd_ready = ~r_rsp_valid | bus.icb_rsp_ready;
  assign w_cmd_hs      = bus.icb_cmd_valid & bus.icb_cmd_ready;
  assign w_addr_err    = |bus.icb_cmd_addr[11:4];
  assign w_wr          = w_cmd_hs & ~bus.icb_cmd_read & ~w_addr_err;
  assign w_sel         = {bus.icb_cmd_addr[3:2], 2'b00};
  assign w_bmask       = extrap_bmask(bus.icb_cmd_wmask);
  assign w_bus_clr     = (w_wr && w_sel == EXTRAP_IP) ? (bus.icb_cmd_wdata & w_bmask) : 32'd0;
  assign w_ack         = (r_state == EXTRAP_ST_OFFER) & bus.trap_ready_i;
  assign w_ack_clr     = w_ack ? (32'd1 << r_id) : 32'd0;
  assign w_unused_addr = ^{bus.icb_cmd_addr[31:12], bus.icb_cmd_addr[1:0]};

  // Register file: IE/EDGE byte-masked writes, IP with set-over-clear priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ie   <= '0;
      r_edge <= '0;
      r_ip   <= '0;
    end else begin
      if (w_wr && w_sel == EXTRAP_IE)
        r_ie <= ((r_ie & ~w_bmask) | (bus.icb_cmd_wdata & w_bmask)) & C_IRQ_MASK;
      if (w_wr && w_sel == EXTRAP_EDGE)
        r_edge <= ((r_edge & ~w_bmask) | (bus.icb_cmd_wdata & w_bmask)) & C_IRQ_MASK;
      r_ip <= ((r_ip & ~(w_bus_clr | w_ack_clr)) | w_set) & C_IRQ_MASK;
    end
  end

  // Read mux reflecting register state at the acceptance edge
  always_comb begin
    w_rd_data = 32'd0;
    case (w_sel)
      EXTRAP_IE:   w_rd_data = r_ie;
      EXTRAP_IP:   w_rd_data = r_ip;
      EXTRAP_EDGE: w_rd_data = r_edge;
      EXTRAP_CUR:  w_rd_data = {w_trap_valid, 26'd0, r_id};
      default:     w_rd_data = 32'd0;
    endcase
  end

  // Response channel: raise after acceptance, hold until the master takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (w_cmd_hs) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_addr_err;
      r_rsp_rdata <= (bus.icb_cmd_read && !w_addr_err) ? w_rd_data : 32'd0;
    end else if (bus.icb_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.icb_rsp_valid = r_rsp_valid;
  assign bus.icb_rsp_err   = r_rsp_err;
  assign bus.icb_rsp_rdata = r_rsp_rdata;

  prio_enc32 u_prio (
    .i_req (r_ip & r_ie),
    .o_any (w_any),
    .o_id  (w_enc_id)
  );

  // FSM state and offered-ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EXTRAP_ST_IDLE;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_id_load) r_id <= w_enc_id;
    end
  end

  // Next state: an offer, once made, is only left through the core's ready
  always_comb begin
    w_state_nxt  = r_state;
    w_id_load    = 1'b0;
    w_trap_valid = 1'b0;
    case (r_state)
      EXTRAP_ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = EXTRAP_ST_OFFER;
          w_id_load   = 1'b1;
        end
      end
      EXTRAP_ST_OFFER: begin
        w_trap_valid = 1'b1;
        if (bus.trap_ready_i) w_state_nxt = EXTRAP_ST_IDLE;
      end
      default: w_state_nxt = EXTRAP_ST_IDLE;
    endcase
  end

  assign bus.trap_valid_o = w_trap_valid;
  assign bus.trap_id_o    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_ex_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_trap_ctrl
// Description : Self-checking bench for ex_trap_ctrl: table-driven register
//               vectors, directed trap sequences, randomized reference check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_trap_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] irq;
  int          n_chk;
  int          n_fail;
  logic        hold_chk;

  ex_trap_ctrl_if bus ();

  ex_trap_ctrl #(.IRQ_NUM(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .irq_i (irq),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rd;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } bus_vec_t;

  // Reference model state
  logic [31:0] m_ie, m_edge, m_ip, m_qd;
  logic        m_offer;
  int          m_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    irq = '0;
    bus.icb_cmd_valid = 1'b0;
    bus.icb_cmd_addr = '0;
    bus.icb_cmd_read = 1'b0;
    bus.icb_cmd_wdata = '0;
    bus.icb_cmd_wmask = '0;
    bus.icb_rsp_ready = 1'b1;
    bus.trap_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic icb_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic rd,
                          output logic [31:0] rdata, output logic err);
    int n;
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_addr = addr;
    bus.icb_cmd_read = rd;
    bus.icb_cmd_wdata = wdata;
    bus.icb_cmd_wmask = wmask;
    bus.icb_rsp_ready = 1'b1;
    n = 0;
    while (!bus.icb_cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("icb cmd_ready timeout", 32'd0, 32'd1);
    tick();
    bus.icb_cmd_valid = 1'b0;
    chk("icb rsp_valid", {31'd0, bus.icb_rsp_valid}, 32'd1);
    rdata = bus.icb_rsp_rdata;
    err = bus.icb_rsp_err;
    tick();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic e;
    icb_xfer(addr, data, 4'hF, 1'b0, d, e);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic e;
    icb_xfer(addr, 32'd0, 4'h0, 1'b1, d, e);
    chk(name, d, exp);
  endtask

  function automatic int lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One clock of the behavioural model, using the inputs present before the edge
  task automatic model_step(input logic [31:0] irqv, input logic rdy);
    logic [31:0] setv, clr, pend;
    setv = (m_edge & irqv & ~m_qd) | (~m_edge & irqv);
    pend = m_ip & m_ie;
    clr = '0;
    if (m_offer) begin
      if (rdy) begin
        clr[m_id] = 1'b1;
        m_offer = 1'b0;
      end
    end else if (pend != 0) begin
      m_id = lowest(pend);
      m_offer = 1'b1;
    end
    m_ip = (m_ip & ~clr) | setv;
    m_qd = irqv;
  endtask

  // Offer stability monitor while the core withholds ready
  always @(negedge clk) begin
    if (hold_chk) begin
      chk("hold valid", {31'd0, bus.trap_valid_o}, 32'd1);
      chk("hold id", {27'd0, bus.trap_id_o}, 32'd1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_vec_t    vt[14];
    logic [31:0] d;
    logic        e;
    int          cyc_q[$];
    int          id_q[$];
    int          n;
    int          nv;

    n_chk = 0;
    n_fail = 0;
    hold_chk = 1'b0;

    vt[0]  = '{32'h0,  32'h0000_00FF, 4'b0001, 1'b0, 32'h0,         1'b0};
    vt[1]  = '{32'h0,  32'h0,         4'b0000, 1'b1, 32'h0000_00FF, 1'b0};
    vt[2]  = '{32'h0,  32'hFFFF_FFFF, 4'b0010, 1'b0, 32'h0,         1'b0};
    vt[3]  = '{32'h0,  32'h0,         4'b0000, 1'b1, 32'h0000_FFFF, 1'b0};
    vt[4]  = '{32'h8,  32'h1234_5678, 4'b1111, 1'b0, 32'h0,         1'b0};
    vt[5]  = '{32'h8,  32'h0,         4'b0000, 1'b1, 32'h1234_5678, 1'b0};
    vt[6]  = '{32'h4,  32'h0,         4'b0000, 1'b1, 32'h0,         1'b0};
    vt[7]  = '{32'h10, 32'h0,         4'b0000, 1'b1, 32'h0,         1'b1};
    vt[8]  = '{32'h20, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0,         1'b1};
    vt[9]  = '{32'h0,  32'h0,         4'b0000, 1'b1, 32'h0000_FFFF, 1'b0};
    vt[10] = '{32'hC,  32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0,         1'b0};
    vt[11] = '{32'hC,  32'h0,         4'b0000, 1'b1, 32'h0,         1'b0};
    vt[12] = '{32'h0,  32'h0,         4'b1111, 1'b0, 32'h0,         1'b0};
    vt[13] = '{32'h0,  32'h0,         4'b0000, 1'b1, 32'h0,         1'b0};

    // Reset state
    do_reset();
    chk("reset valid", {31'd0, bus.trap_valid_o}, 32'd0);
    chk("reset id", {27'd0, bus.trap_id_o}, 32'd0);
    chk("reset rsp_valid", {31'd0, bus.icb_rsp_valid}, 32'd0);
    chk("reset rsp_err", {31'd0, bus.icb_rsp_err}, 32'd0);
    chk("reset rsp_rdata", bus.icb_rsp_rdata, 32'd0);
    chk("reset cmd_ready", {31'd0, bus.icb_cmd_ready}, 32'd1);

    // Register vectors
    for (int i = 0; i < 14; i++) begin
      icb_xfer(vt[i].addr, vt[i].wdata, vt[i].wmask, vt[i].rd, d, e);
      chk($sformatf("vec%0d err", i), {31'd0, e}, {31'd0, vt[i].exp_err});
      if (vt[i].rd) chk($sformatf("vec%0d rdata", i), d, vt[i].exp_rdata);
    end

    // Edge-triggered delivery with ready tied high
    do_reset();
    wr(32'h0, 32'h12);
    wr(32'h8, 32'h12);
    bus.trap_ready_i = 1'b1;
    irq = 32'h10;
    tick();
    irq = 32'h0;
    chk("edge valid after IP set", {31'd0, bus.trap_valid_o}, 32'd0);
    tick();
    chk("edge valid", {31'd0, bus.trap_valid_o}, 32'd1);
    chk("edge id", {27'd0, bus.trap_id_o}, 32'd4);
    tick();
    chk("edge valid drop", {31'd0, bus.trap_valid_o}, 32'd0);
    nv = 0;
    repeat (5) begin
      tick();
      if (bus.trap_valid_o) nv++;
    end
    chk("edge no re-offer", nv, 32'd0);
    rd_chk("edge IP after", 32'h4, 32'h0);

    // Priority and back-to-back order
    do_reset();
    wr(32'h0, 32'h12);
    wr(32'h8, 32'h12);
    bus.trap_ready_i = 1'b1;
    irq = 32'h12;
    tick();
    irq = 32'h0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.trap_valid_o) begin
        cyc_q.push_back(k);
        id_q.push_back(int'(bus.trap_id_o));
      end
    end
    chk("prio offer count", cyc_q.size(), 32'd2);
    if (cyc_q.size() == 2) begin
      chk("prio first id", id_q[0], 32'd1);
      chk("prio second id", id_q[1], 32'd4);
      chk("prio idle gap", {31'd0, (cyc_q[1] - cyc_q[0]) >= 2}, 32'd1);
    end

    // Offer held while the core is not ready
    do_reset();
    wr(32'h0, 32'h12);
    wr(32'h8, 32'h12);
    bus.trap_ready_i = 1'b0;
    irq = 32'h2;
    tick();
    irq = 32'h0;
    n = 0;
    while (!bus.trap_valid_o && n < 10) begin
      tick();
      n++;
    end
    chk("hold offer seen", {31'd0, bus.trap_valid_o}, 32'd1);
    hold_chk = 1'b1;
    icb_xfer(32'h4, 32'h2, 4'hF, 1'b0, d, e);
    icb_xfer(32'h0, 32'h10, 4'hF, 1'b0, d, e);
    tick();
    hold_chk = 1'b0;
    chk("hold valid end", {31'd0, bus.trap_valid_o}, 32'd1);
    chk("hold id end", {27'd0, bus.trap_id_o}, 32'd1);
    bus.trap_ready_i = 1'b1;
    tick();
    chk("hold delivered", {31'd0, bus.trap_valid_o}, 32'd0);
    nv = 0;
    repeat (4) begin
      tick();
      if (bus.trap_valid_o) nv++;
    end
    chk("hold no re-offer", nv, 32'd0);
    rd_chk("hold IP after", 32'h4, 32'h0);

    // Level mode re-offer
    do_reset();
    wr(32'h0, 32'h1);
    wr(32'h8, 32'h0);
    bus.trap_ready_i = 1'b1;
    irq = 32'h1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("level valid k%0d", k), {31'd0, bus.trap_valid_o}, {31'd0, (k % 2) == 0});
      if (bus.trap_valid_o) chk("level id", {27'd0, bus.trap_id_o}, 32'd0);
    end
    irq = 32'h0;
    repeat (6) tick();
    nv = 0;
    repeat (6) begin
      tick();
      if (bus.trap_valid_o) nv++;
    end
    chk("level stops", nv, 32'd0);
    rd_chk("level IP after", 32'h4, 32'h0);

    // rsp_ready held low blocks further commands
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_addr = 32'h0;
    bus.icb_cmd_read = 1'b1;
    bus.icb_rsp_ready = 1'b0;
    chk("stall cmd_ready before", {31'd0, bus.icb_cmd_ready}, 32'd1);
    tick();
    bus.icb_cmd_valid = 1'b0;
    repeat (4) begin
      chk("stall rsp_valid", {31'd0, bus.icb_rsp_valid}, 32'd1);
      chk("stall cmd_ready", {31'd0, bus.icb_cmd_ready}, 32'd0);
      chk("stall rdata", bus.icb_rsp_rdata, 32'h1);
      tick();
    end
    bus.icb_rsp_ready = 1'b1;
    #1;
    chk("stall cmd_ready release", {31'd0, bus.icb_cmd_ready}, 32'd1);
    tick();
    chk("stall rsp consumed", {31'd0, bus.icb_rsp_valid}, 32'd0);

    // Edge coinciding with W1C: set wins
    do_reset();
    wr(32'h8, 32'h4);
    irq = 32'h4;
    tick();
    irq = 32'h0;
    tick();
    rd_chk("w1c IP preset", 32'h4, 32'h4);
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_addr = 32'h4;
    bus.icb_cmd_read = 1'b0;
    bus.icb_cmd_wdata = 32'h4;
    bus.icb_cmd_wmask = 4'hF;
    irq = 32'h4;
    tick();
    bus.icb_cmd_valid = 1'b0;
    tick();
    rd_chk("w1c set wins", 32'h4, 32'h4);
    wr(32'h4, 32'h4);
    rd_chk("w1c clears", 32'h4, 32'h0);
    irq = 32'h0;

    // Asynchronous reset during an offer
    do_reset();
    wr(32'h0, 32'h12);
    wr(32'h8, 32'h12);
    bus.trap_ready_i = 1'b0;
    irq = 32'h10;
    tick();
    irq = 32'h0;
    tick();
    chk("rst offer up", {31'd0, bus.trap_valid_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst valid async drop", {31'd0, bus.trap_valid_o}, 32'd0);
    chk("rst id", {27'd0, bus.trap_id_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd_chk("rst IE", 32'h0, 32'h0);
    rd_chk("rst IP", 32'h4, 32'h0);
    rd_chk("rst EDGE", 32'h8, 32'h0);
    rd_chk("rst CUR", 32'hC, 32'h0);

    // Randomized traffic against the reference model
    do_reset();
    m_ie = $urandom;
    m_edge = $urandom;
    m_ip = '0;
    m_qd = '0;
    m_offer = 1'b0;
    m_id = 0;
    wr(32'h0, m_ie);
    wr(32'h8, m_edge);
    for (int c = 0; c < 440; c++) begin
      if (c < 400) begin
        irq = $urandom & $urandom & $urandom;
        bus.trap_ready_i = 1'($urandom_range(0, 1));
      end else begin
        irq = '0;
        bus.trap_ready_i = 1'b1;
      end
      model_step(irq, bus.trap_ready_i);
      tick();
      if (bus.trap_valid_o !== m_offer) begin
        chk($sformatf("rand valid c%0d", c), {31'd0, bus.trap_valid_o}, {31'd0, m_offer});
      end else begin
        chk("rand valid", {31'd0, bus.trap_valid_o}, {31'd0, m_offer});
        if (m_offer) chk($sformatf("rand id c%0d", c), {27'd0, bus.trap_id_o}, m_id);
      end
    end
    irq = '0;
    rd_chk("rand final IP", 32'h4, m_ip);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
